gpio_pad_bank: RTL
==================

// Module: gpio_pad_bank
// PURPOSE
//  Parametrised GPIO pad-control bank between the SoC GPIO peripheral and the
//  PDDW0204CDG bidirectional pad cells. Each pin has its own 2-bit mode, in place
//  of a single mode shared by all pins. Each pin derives its own pad controls
//  (OEN/IE/DS) from that mode. The input path has a synchroniser, a programmable
//  debounce filter, rise/fall edge detection and sticky per-pin interrupt
//  pending bits.
// PARAMETERS
//  N_PINS       16  number of GPIO pins in the bank
//  SYNC_STAGES  2   input synchroniser depth (>=2)
//  DEB_W        8   debounce counter / limit width
// PORTS
//  clk          in   1          core clock
//  rst          in   1          asynchronous reset, active-low
//  io_ctrl      in   2*N_PINS   per-pin mode; bits [2i+1:2i] belong to pin i
//  gpio_out     in   N_PINS     output data from the peripheral
//  pad_c        in   N_PINS     pad cell C outputs (raw pad level)
//  pad_i        out  N_PINS     pad cell I inputs
//  pad_oen      out  N_PINS     pad cell OEN (0 = drive)
//  pad_ie       out  N_PINS     pad cell IE
//  pad_ds       out  N_PINS     pad cell DS
//  deb_limit    in   DEB_W      debounce length in cycles; shared by all pins
//  irq_en_rise  in   N_PINS     per-pin rising-edge interrupt enable
//  irq_en_fall  in   N_PINS     per-pin falling-edge interrupt enable
//  irq_clr      in   N_PINS     per-pin write-1 clear of pending, single-cycle pulse
//  gpio_in      out  N_PINS     debounced stable input level
//  irq_pend     out  N_PINS     sticky pending edge flags
//  irq          out  1          OR of all irq_pend bits
// BEHAVIOUR
//  Pad mode decode (combinational, per pin):
//   00 hi-z: OEN=1, IE=0, DS=1
//   01 out:  OEN=0, IE=0, DS=1
//   10 in:   OEN=1, IE=1, DS=0
//   11 hi-z: same as 00
//   pad_i = gpio_out in every mode.
//  Registered state, per pin: sync chain, debounce cnt, stable, pend.
//   - All registers clear to 0 asynchronously when rst=0.
//   - After reset: gpio_in=0, irq_pend=0, irq=0.
//  Pin not in mode 10:
//   - sync chain, cnt and stable are cleared synchronously to 0.
//   - No edge is produced.
//   - pend keeps its value and still honours irq_clr.
//  Pin in mode 10:
//   - pad_c shifts through SYNC_STAGES flops; call the last flop s.
//   - s == stable: cnt <= 0.
//   - s != stable and cnt >= deb_limit: stable <= s, cnt <= 0; this is an edge.
//   - s != stable otherwise: cnt <= cnt+1. cnt saturates, never wraps.
//  Timing:
//   - A pad step held steady reaches gpio_in on edge SYNC_STAGES+1+deb_limit.
//   - deb_limit=0 is a pass-through after the synchroniser.
//   - A pulse shorter than deb_limit+1 cycles at s never changes gpio_in.
//  Edges and pending:
//   - rise = stable 0->1; fall = stable 1->0. Edges are evaluated on the same
//     edge that updates stable.
//   - pend[i] is set on (rise & irq_en_rise[i]) | (fall & irq_en_fall[i]).
//   - pend[i] is cleared by irq_clr[i]. If set and clear occur on the same edge,
//     set wins.
//   - irq_pend and gpio_in change on the same clock edge.
//   - irq is combinational from irq_pend.
//  deb_limit changed mid-count: the new value applies from the next compare;
//   there is no reset of cnt.
//  Enable deasserted while pend=1: pend stays set until irq_clr.
//  Reset asserted mid-debounce: all state returns to 0 immediately, with no
//   glitch-free requirement on irq.
// TESTING
//  T1 io_ctrl pin0=01, pin1=10, pin2=00, pin3=11:
//     pin0 OEN/IE/DS=0/0/1, pin1 1/1/0, pin2 1/0/1, pin3 1/0/1;
//     pad_i follows gpio_out on all pins.
//  T2 pin5 mode 10, deb_limit=0, irq_en_rise[5]=1; pad_c[5] 0->1 at cycle 0:
//     gpio_in[5]=1 and irq_pend[5]=1 after edge 3; irq=1.
//  T3 deb_limit=4, pin5 input; pad_c[5] high for 4 cycles then low:
//     gpio_in[5] stays 0, no pend. Held high >=5 cycles:
//     gpio_in[5]=1 after edge 7.
//  T4 pend[5]=1; irq_clr[5] pulse on the same edge as a new enabled fall edge:
//     pend[5] stays 1. Next clear alone: pend[5]=0, irq=0.
//  T5 pin7 input with gpio_in[7]=1; io_ctrl pin7 -> 01:
//     gpio_in[7]=0 next edge; no fall pend even with irq_en_fall[7]=1.
//  T6 rst low mid-debounce (cnt=3, pend=0xFFFF):
//     gpio_in=0, irq_pend=0, irq=0 asynchronously.
//     After release, a full debounce time is needed again.

Source files
------------

// File: rtl/gpio_pad_bank.sv
// GPIO pad-control bank: per-pin mode decode to PDDW0204CDG pad controls,
// plus an input path with synchroniser, debounce filter, edge detection and
// sticky per-pin interrupt pending flags.
module gpio_pad_bank #(
  parameter int N_PINS      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*N_PINS-1:0]   io_ctrl,
  input  logic [N_PINS-1:0]     gpio_out,
  input  logic [N_PINS-1:0]     pad_c,
  output logic [N_PINS-1:0]     pad_i,
  output logic [N_PINS-1:0]     pad_oen,
  output logic [N_PINS-1:0]     pad_ie,
  output logic [N_PINS-1:0]     pad_ds,
  input  logic [DEB_W-1:0]      deb_limit,
  input  logic [N_PINS-1:0]     irq_en_rise,
  input  logic [N_PINS-1:0]     irq_en_fall,
  input  logic [N_PINS-1:0]     irq_clr,
  output logic [N_PINS-1:0]     gpio_in,
  output logic [N_PINS-1:0]     irq_pend,
  output logic                  irq
);

  localparam logic [1:0] MODE_HIZ  = 2'b00;
  localparam logic [1:0] MODE_OUT  = 2'b01;
  localparam logic [1:0] MODE_IN   = 2'b10;
  localparam logic [1:0] MODE_HIZ2 = 2'b11;

  // The pad always sees the peripheral's output data; OEN decides if it drives.
  assign pad_i = gpio_out;

  genvar gi;
  for (gi = 0; gi < N_PINS; gi++) begin : g_pin
    logic [1:0]             mode;
    logic                   is_in;
    logic                   oen;
    logic                   ie;
    logic                   ds;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [DEB_W-1:0]       cnt_q;
    logic [DEB_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   pend_q;
    logic                   pend_d;
    logic                   s;
    logic                   rise;
    logic                   fall;

    assign mode  = io_ctrl[2*gi+1:2*gi];
    assign is_in = (mode == MODE_IN);
    assign s     = sync_q[SYNC_STAGES-1];

    // Pad control decode; both hi-z encodings behave identically.
    always_comb begin
      oen = 1'b1;
      ie  = 1'b0;
      ds  = 1'b1;
      case (mode)
        MODE_OUT: begin
          oen = 1'b0;
          ie  = 1'b0;
          ds  = 1'b1;
        end
        MODE_IN: begin
          oen = 1'b1;
          ie  = 1'b1;
          ds  = 1'b0;
        end
        MODE_HIZ, MODE_HIZ2: begin
          oen = 1'b1;
          ie  = 1'b0;
          ds  = 1'b1;
        end
        default: begin
          oen = 1'b1;
          ie  = 1'b0;
          ds  = 1'b1;
        end
      endcase
    end

    // Synchroniser shifts only while the pin is an input; otherwise it is flushed.
    always_comb begin
      sync_d = '0;
      if (is_in) begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_c[gi]};
      end
    end

    // Debounce: a differing level must persist past deb_limit before it is accepted.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise     = 1'b0;
      fall     = 1'b0;
      if (!is_in) begin
        cnt_d    = '0;
        stable_d = 1'b0;
      end else if (s == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q >= deb_limit) begin
        stable_d = s;
        cnt_d    = '0;
        rise     = s;
        fall     = ~s;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Pending flag: a new enabled edge takes priority over a same-cycle clear.
    always_comb begin
      pend_d = (pend_q & ~irq_clr[gi])
             | (rise & irq_en_rise[gi])
             | (fall & irq_en_fall[gi]);
    end

    // Per-pin state registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q   <= '0;
        cnt_q    <= '0;
        stable_q <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        pend_q   <= pend_d;
      end
    end

    assign pad_oen[gi]  = oen;
    assign pad_ie[gi]   = ie;
    assign pad_ds[gi]   = ds;
    assign gpio_in[gi]  = stable_q;
    assign irq_pend[gi] = pend_q;
  end

  assign irq = |irq_pend;

endmodule
